// File: rtl/elevator_shaft_model_if.sv
// rtl/elevator_shaft_model_if.sv - controller-to-shaft signal bundle for elevator_shaft_model
interface elevator_shaft_model_if;
    logic [1:0] ac;
    logic       door_open;
    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] floor;
    logic       moving;
    logic       fault;
    logic [7:0] trips;

    // Controller side: issues motor commands, observes the plant
    modport master (
        output ac,
        output door_open,
        input  s1,
        input  s2,
        input  s3,
        input  floor,
        input  moving,
        input  fault,
        input  trips
    );

    // Plant side: the shaft model itself
    modport slave (
        input  ac,
        input  door_open,
        output s1,
        output s2,
        output s3,
        output floor,
        output moving,
        output fault,
        output trips
    );
endinterface

// File: rtl/elevator_shaft_model.sv
// rtl/elevator_shaft_model.sv - three-floor elevator plant model; SHAFT_SENSOR_LEVEL_EN selects level sensors
module elevator_shaft_model #(
    parameter int TRAVEL_CYCLES = 8
) (
    input logic                   clk,
    input logic                   rst,
    elevator_shaft_model_if.slave bus
);

    localparam logic [1:0] PARKED = 2'd0;
    localparam logic [1:0] UP     = 2'd1;
    localparam logic [1:0] DOWN   = 2'd2;
    localparam logic [1:0] FAULT  = 2'd3;

    localparam logic [1:0] AC_STOP = 2'b00;
    localparam logic [1:0] AC_UP   = 2'b10;
    localparam logic [1:0] AC_DOWN = 2'b01;
    localparam logic [1:0] AC_BAD  = 2'b11;

    // The arrival is committed on the edge where the counter would reach
    // TRAVEL_CYCLES-1, so the new floor is visible TRAVEL_CYCLES cycles
    // after the command cycle that left PARKED.
    localparam logic [7:0] LAST_STEP = 8'(TRAVEL_CYCLES - 2);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] count;
    logic [7:0] count_next;
    logic [1:0] floor_q;
    logic [1:0] floor_next;
    logic [7:0] trips_q;
    logic [7:0] trips_next;
    logic       moving_q;
    logic       fault_q;
    logic [2:0] sens_q;
    logic [2:0] sens_next;
    logic       arrive;
    logic       violation;
    logic       common_bad;

    // Plant violations; these preempt every normal transition
    always_comb begin
        common_bad = (bus.ac == AC_BAD) || (bus.door_open && (bus.ac != AC_STOP));
        violation  = 1'b0;
        case (state)
            PARKED: violation = common_bad
                              || ((bus.ac == AC_UP)   && (floor_q == 2'd3))
                              || ((bus.ac == AC_DOWN) && (floor_q == 2'd1));
            UP:     violation = common_bad || (bus.ac == AC_DOWN);
            DOWN:   violation = common_bad || (bus.ac == AC_UP);
            default: violation = 1'b0;
        endcase
    end

    // Next state, travel counter, floor and trip count
    always_comb begin
        state_next = state;
        count_next = count;
        floor_next = floor_q;
        arrive     = 1'b0;
        case (state)
            PARKED: begin
                if (violation) begin
                    state_next = FAULT;
                end else if (bus.ac == AC_UP) begin
                    state_next = UP;
                    count_next = 8'd0;
                end else if (bus.ac == AC_DOWN) begin
                    state_next = DOWN;
                    count_next = 8'd0;
                end
            end
            UP: begin
                if (violation) begin
                    state_next = FAULT;
                end else if (bus.ac == AC_UP) begin
                    if (count == LAST_STEP) begin
                        arrive     = 1'b1;
                        floor_next = floor_q + 2'd1;
                        state_next = PARKED;
                        count_next = 8'd0;
                    end else begin
                        count_next = count + 8'd1;
                    end
                end
            end
            DOWN: begin
                if (violation) begin
                    state_next = FAULT;
                end else if (bus.ac == AC_DOWN) begin
                    if (count == LAST_STEP) begin
                        arrive     = 1'b1;
                        floor_next = floor_q - 2'd1;
                        state_next = PARKED;
                        count_next = 8'd0;
                    end else begin
                        count_next = count + 8'd1;
                    end
                end
            end
            default: state_next = FAULT;
        endcase
        trips_next = trips_q;
        if (arrive && (trips_q != 8'hff)) begin
            trips_next = trips_q + 8'd1;
        end
    end

    // Floor sensor image for the coming cycle, one-hot or all-zero
    always_comb begin
        sens_next = 3'b000;
`ifdef SHAFT_SENSOR_LEVEL_EN
        if (state_next == PARKED) begin
            sens_next = {floor_next == 2'd3, floor_next == 2'd2, floor_next == 2'd1};
        end
`else
        if (arrive) begin
            sens_next = {floor_next == 2'd3, floor_next == 2'd2, floor_next == 2'd1};
        end
`endif
    end

    // Register every output alongside the state; reset wins over all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PARKED;
            count    <= 8'd0;
            floor_q  <= 2'd1;
            trips_q  <= 8'd0;
            moving_q <= 1'b0;
            fault_q  <= 1'b0;
            sens_q   <= 3'b000;
        end else begin
            state    <= state_next;
            count    <= count_next;
            floor_q  <= floor_next;
            trips_q  <= trips_next;
            moving_q <= (state_next == UP) || (state_next == DOWN);
            fault_q  <= (state_next == FAULT);
            sens_q   <= sens_next;
        end
    end

    assign bus.floor  = floor_q;
    assign bus.trips  = trips_q;
    assign bus.moving = moving_q;
    assign bus.fault  = fault_q;
    assign bus.s1     = sens_q[0];
    assign bus.s2     = sens_q[1];
    assign bus.s3     = sens_q[2];

endmodule
